// File: rtl/mem_wb_pipe_pkg.sv
// Shared definitions for the MEM->WB boundary: default widths, the link
// register index and the control bundle carried through each stage.
package mem_wb_pipe_pkg;

  localparam int NB_DATA_DEF   = 32;
  localparam int NB_REG_DEF    = 5;
  localparam int NB_PC_DEF     = 32;
  localparam int NB_CNT_DEF    = 32;
  localparam int MAX_STAGES    = 4;

  // Link instructions always write the return address here.
  localparam logic [4:0] REG_RA = 5'd31;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic r31_ctrl;
    logic halt;
  } wb_ctrl_t;

endpackage

// File: rtl/mem_wb_stage.sv
// One MEM->WB register slice: valid, control bundle and data fields.
// Clear wins over load so a flush drops the slot even when the pipe is stalled.
module mem_wb_stage
  import mem_wb_pipe_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_REG  = NB_REG_DEF,
  parameter int NB_PC   = NB_PC_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic               i_valid,
  input  wb_ctrl_t           i_ctrl,
  input  logic [NB_DATA-1:0] i_mem_data,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic [NB_REG-1:0]  i_reg,
  input  logic [NB_PC-1:0]   i_pc,
  output logic               o_valid,
  output wb_ctrl_t           o_ctrl,
  output logic [NB_DATA-1:0] o_mem_data,
  output logic [NB_DATA-1:0] o_alu_result,
  output logic [NB_REG-1:0]  o_reg,
  output logic [NB_PC-1:0]   o_pc
);

  logic               r_valid;
  wb_ctrl_t           r_ctrl;
  logic [NB_DATA-1:0] r_mem_data;
  logic [NB_DATA-1:0] r_alu_result;
  logic [NB_REG-1:0]  r_reg;
  logic [NB_PC-1:0]   r_pc;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_valid      <= 1'b0;
      r_ctrl       <= '0;
      r_mem_data   <= '0;
      r_alu_result <= '0;
      r_reg        <= '0;
      r_pc         <= '0;
    end else if (i_clear) begin
      r_valid      <= 1'b0;
    end else if (i_load) begin
      r_valid      <= i_valid;
      r_ctrl       <= i_ctrl;
      r_mem_data   <= i_mem_data;
      r_alu_result <= i_alu_result;
      r_reg        <= i_reg;
      r_pc         <= i_pc;
    end
  end

  assign o_valid      = r_valid;
  assign o_ctrl       = r_ctrl;
  assign o_mem_data   = r_mem_data;
  assign o_alu_result = r_alu_result;
  assign o_reg        = r_reg;
  assign o_pc         = r_pc;

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline boundary of 1..4 slices with stall, flush, a sticky halt
// flag, a saturating retired-instruction counter and the write-back mux.
module mem_wb_pipe
  import mem_wb_pipe_pkg::*;
#(
  parameter int NB_DATA   = NB_DATA_DEF,
  parameter int NB_REG    = NB_REG_DEF,
  parameter int NB_PC     = NB_PC_DEF,
  parameter int NB_STAGES = 1,
  parameter int NB_CNT    = NB_CNT_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_enable,
  input  logic               i_flush,
  input  logic               i_MEM_valid,
  input  logic               i_MEM_reg_write,
  input  logic               i_MEM_mem_to_reg,
  input  logic               i_MEM_r31_ctrl,
  input  logic               i_MEM_halt,
  input  logic [NB_DATA-1:0] i_MEM_mem_data,
  input  logic [NB_DATA-1:0] i_MEM_alu_result,
  input  logic [NB_REG-1:0]  i_MEM_selected_reg,
  input  logic [NB_PC-1:0]   i_MEM_pc,
  output logic               o_WB_valid,
  output logic               o_WB_reg_write,
  output logic [NB_REG-1:0]  o_WB_write_reg,
  output logic [NB_DATA-1:0] o_WB_write_data,
  output logic               o_halted,
  output logic [NB_CNT-1:0]  o_retired_count
);

  if (NB_STAGES < 1 || NB_STAGES > MAX_STAGES) begin : g_bad_stages
    $error("mem_wb_pipe: NB_STAGES must be in 1..4");
  end
  if (NB_PC > NB_DATA) begin : g_bad_pc
    $error("mem_wb_pipe: NB_PC must not exceed NB_DATA");
  end

  function automatic logic [NB_CNT-1:0] sat_inc(input logic [NB_CNT-1:0] v);
    return (&v) ? v : v + NB_CNT'(1);
  endfunction

  // Index 0 is the MEM input side; index NB_STAGES is the final (WB) slice.
  logic               w_valid      [NB_STAGES+1];
  wb_ctrl_t           w_ctrl       [NB_STAGES+1];
  logic [NB_DATA-1:0] w_mem_data   [NB_STAGES+1];
  logic [NB_DATA-1:0] w_alu_result [NB_STAGES+1];
  logic [NB_REG-1:0]  w_reg        [NB_STAGES+1];
  logic [NB_PC-1:0]   w_pc         [NB_STAGES+1];

  logic               r_halted;
  logic [NB_CNT-1:0]  r_count;
  logic               w_load;
  logic               w_clear;
  logic               w_final_load;

  assign w_valid[0]      = i_MEM_valid;
  assign w_ctrl[0]       = '{reg_write:  i_MEM_reg_write,
                             mem_to_reg: i_MEM_mem_to_reg,
                             r31_ctrl:   i_MEM_r31_ctrl,
                             halt:       i_MEM_halt};
  assign w_mem_data[0]   = i_MEM_mem_data;
  assign w_alu_result[0] = i_MEM_alu_result;
  assign w_reg[0]        = i_MEM_selected_reg;
  assign w_pc[0]         = i_MEM_pc;

  // Once halted, neither enable nor flush may touch the slices.
  assign w_load       = i_enable & ~i_flush & ~r_halted;
  assign w_clear      = i_flush & ~r_halted;
  assign w_final_load = w_load & w_valid[NB_STAGES-1];

  for (genvar g = 0; g < NB_STAGES; g++) begin : g_stage
    mem_wb_stage #(
      .NB_DATA (NB_DATA),
      .NB_REG  (NB_REG),
      .NB_PC   (NB_PC)
    ) u_stage (
      .i_clock      (i_clock),
      .i_reset_n    (i_reset_n),
      .i_load       (w_load),
      .i_clear      (w_clear),
      .i_valid      (w_valid[g]),
      .i_ctrl       (w_ctrl[g]),
      .i_mem_data   (w_mem_data[g]),
      .i_alu_result (w_alu_result[g]),
      .i_reg        (w_reg[g]),
      .i_pc         (w_pc[g]),
      .o_valid      (w_valid[g+1]),
      .o_ctrl       (w_ctrl[g+1]),
      .o_mem_data   (w_mem_data[g+1]),
      .o_alu_result (w_alu_result[g+1]),
      .o_reg        (w_reg[g+1]),
      .o_pc         (w_pc[g+1])
    );
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_halted <= 1'b0;
    end else if (w_final_load && w_ctrl[NB_STAGES-1].halt) begin
      r_halted <= 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (w_final_load) begin
      r_count <= sat_inc(r_count);
    end
  end

  // Write-back mux reads only the final slice, so nothing from MEM leaks through.
  always_comb begin
    o_WB_reg_write  = 1'b0;
    o_WB_write_reg  = '0;
    o_WB_write_data = '0;
    if (w_valid[NB_STAGES]) begin
      o_WB_reg_write = w_ctrl[NB_STAGES].reg_write;
      if (w_ctrl[NB_STAGES].r31_ctrl) begin
        o_WB_write_reg  = NB_REG'(REG_RA);
        o_WB_write_data = NB_DATA'(w_pc[NB_STAGES]);
      end else begin
        o_WB_write_reg  = w_reg[NB_STAGES];
        o_WB_write_data = w_ctrl[NB_STAGES].mem_to_reg ? w_mem_data[NB_STAGES]
                                                       : w_alu_result[NB_STAGES];
      end
    end
  end

  assign o_WB_valid      = w_valid[NB_STAGES];
  assign o_halted        = r_halted;
  assign o_retired_count = r_count;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Scoreboard bench: a 1-stage and a 3-stage (4-bit counter) pipe share data
// inputs; each has its own control, expected-result queue and monitor.
module tb_mem_wb_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rst3, en1, en3, fl1, fl3, v1, v3;
  logic        rw, mtr, r31, hlt;
  logic [31:0] md, alu, pc;
  logic [4:0]  rg;

  logic        o1_valid, o1_rw, o1_halted;
  logic [4:0]  o1_wr;
  logic [31:0] o1_wd, o1_cnt;
  logic        o3_valid, o3_rw, o3_halted;
  logic [4:0]  o3_wr;
  logic [31:0] o3_wd;
  logic [3:0]  o3_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        hlt;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  logic mh1 = 1'b0;
  logic mh3 = 1'b0;

  mem_wb_pipe #(.NB_DATA(32), .NB_REG(5), .NB_PC(32), .NB_STAGES(1), .NB_CNT(32)) u_dut1 (
    .i_clock(clk), .i_reset_n(rst1), .i_enable(en1), .i_flush(fl1),
    .i_MEM_valid(v1), .i_MEM_reg_write(rw), .i_MEM_mem_to_reg(mtr),
    .i_MEM_r31_ctrl(r31), .i_MEM_halt(hlt), .i_MEM_mem_data(md),
    .i_MEM_alu_result(alu), .i_MEM_selected_reg(rg), .i_MEM_pc(pc),
    .o_WB_valid(o1_valid), .o_WB_reg_write(o1_rw), .o_WB_write_reg(o1_wr),
    .o_WB_write_data(o1_wd), .o_halted(o1_halted), .o_retired_count(o1_cnt)
  );

  mem_wb_pipe #(.NB_DATA(32), .NB_REG(5), .NB_PC(32), .NB_STAGES(3), .NB_CNT(4)) u_dut3 (
    .i_clock(clk), .i_reset_n(rst3), .i_enable(en3), .i_flush(fl3),
    .i_MEM_valid(v3), .i_MEM_reg_write(rw), .i_MEM_mem_to_reg(mtr),
    .i_MEM_r31_ctrl(r31), .i_MEM_halt(hlt), .i_MEM_mem_data(md),
    .i_MEM_alu_result(alu), .i_MEM_selected_reg(rg), .i_MEM_pc(pc),
    .o_WB_valid(o3_valid), .o_WB_reg_write(o3_rw), .o_WB_write_reg(o3_wr),
    .o_WB_write_data(o3_wd), .o_halted(o3_halted), .o_retired_count(o3_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_fields(input logic f_rw, input logic f_mtr, input logic f_r31,
                            input logic f_hlt, input logic [31:0] f_md,
                            input logic [31:0] f_alu, input logic [4:0] f_rg,
                            input logic [31:0] f_pc);
    rw = f_rw; mtr = f_mtr; r31 = f_r31; hlt = f_hlt;
    md = f_md; alu = f_alu; rg = f_rg; pc = f_pc;
  endtask

  task automatic push(input int d, input logic e_rw, input logic [4:0] e_wr,
                      input logic [31:0] e_wd, input logic e_hlt);
    if (d == 1) q1.push_back('{e_rw, e_wr, e_wd, e_hlt});
    else        q3.push_back('{e_rw, e_wr, e_wd, e_hlt});
  endtask

  // Monitor for the 1-stage pipe: pop on each advancing edge that retires.
  always @(posedge clk) begin
    exp_t e1;
    logic a1;
    a1 = rst1 && en1 && !fl1 && !mh1;
    #1;
    if (!rst1) mh1 = 1'b0;
    if (a1 && o1_valid) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL u1_unexpected_retire: got reg=%0d data=0x%0h with empty queue", o1_wr, o1_wd);
      end else begin
        e1 = q1.pop_front();
        chk("u1_reg_write", o1_rw, e1.rw);
        chk("u1_write_reg", o1_wr, e1.wr);
        chk("u1_write_data", o1_wd, e1.wd);
        if (e1.hlt) mh1 = 1'b1;
      end
    end else if (!o1_valid) begin
      chk("u1_bubble_gated", {o1_rw, o1_wr, o1_wd}, 64'h0);
    end
    chk("u1_halted", o1_halted, mh1);
  end

  // Monitor for the 3-stage pipe.
  always @(posedge clk) begin
    exp_t e3;
    logic a3;
    a3 = rst3 && en3 && !fl3 && !mh3;
    #1;
    if (!rst3) mh3 = 1'b0;
    if (a3 && o3_valid) begin
      if (q3.size() == 0) begin
        total++; bad++;
        $display("FAIL u3_unexpected_retire: got reg=%0d data=0x%0h with empty queue", o3_wr, o3_wd);
      end else begin
        e3 = q3.pop_front();
        chk("u3_reg_write", o3_rw, e3.rw);
        chk("u3_write_reg", o3_wr, e3.wr);
        chk("u3_write_data", o3_wd, e3.wd);
        if (e3.hlt) mh3 = 1'b1;
      end
    end else if (!o3_valid) begin
      chk("u3_bubble_gated", {o3_rw, o3_wr, o3_wd}, 64'h0);
    end
    chk("u3_halted", o3_halted, mh3);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst1 = 0; rst3 = 0; en1 = 1; en3 = 1; fl1 = 0; fl3 = 0; v1 = 0; v3 = 0;
    set_fields(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 32'h0);
    repeat (2) @(negedge clk);
    chk("rst_u1_valid", o1_valid, 0);
    chk("rst_u1_count", o1_cnt, 0);
    chk("rst_u3_valid", o3_valid, 0);
    chk("rst_u3_count", o3_cnt, 0);
    chk("rst_u3_halted", o3_halted, 0);
    rst1 = 1; rst3 = 1;
    @(negedge clk);

    // 1-stage: ALU result, load data, and a non-writing instruction.
    set_fields(1, 0, 0, 0, 32'hDEAD_BEEF, 32'h1234, 5'd7, 32'h99);
    v1 = 1; push(1, 1, 5'd7, 32'h1234, 0);
    @(negedge clk);
    chk("t1_write_data", o1_wd, 32'h1234);
    chk("t1_count", o1_cnt, 1);
    set_fields(1, 1, 0, 0, 32'hCAFE_F00D, 32'h5555, 5'd12, 32'h0);
    push(1, 1, 5'd12, 32'hCAFE_F00D, 0);
    @(negedge clk);
    set_fields(0, 0, 0, 0, 32'h0, 32'h5, 5'd3, 32'h0);
    push(1, 0, 5'd3, 32'h5, 0);
    @(negedge clk);
    v1 = 0;
    chk("t1_count3", o1_cnt, 3);

    // 3-stage: link instruction followed by bubbles.
    set_fields(1, 0, 1, 0, 32'h0, 32'h777, 5'd5, 32'h40);
    v3 = 1; push(3, 1, 5'd31, 32'h40, 0);
    @(negedge clk);
    v3 = 0;
    @(negedge clk);
    chk("t2_not_yet", o3_valid, 0);
    @(negedge clk);
    chk("t2_valid", o3_valid, 1);
    chk("t2_write_reg", o3_wr, 31);
    chk("t2_write_data", o3_wd, 32'h40);
    chk("t2_count", o3_cnt, 1);
    @(negedge clk);
    chk("t2_one_cycle", o3_valid, 0);

    // Stall with an entry in flight, then stall with it at WB.
    set_fields(1, 0, 0, 0, 32'h0, 32'hA5A5, 5'd9, 32'h0);
    v3 = 1; push(3, 1, 5'd9, 32'hA5A5, 0);
    @(negedge clk);
    v3 = 0; en3 = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_stall_valid", o3_valid, 0);
      chk("t3_stall_count", o3_cnt, 1);
    end
    en3 = 1;
    @(negedge clk);
    @(negedge clk);
    chk("t3_resumed_valid", o3_valid, 1);
    chk("t3_resumed_count", o3_cnt, 2);
    en3 = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", o3_valid, 1);
      chk("t3_hold_reg", o3_wr, 9);
      chk("t3_hold_data", o3_wd, 32'hA5A5);
      chk("t3_hold_count", o3_cnt, 2);
    end
    en3 = 1;
    @(negedge clk);
    chk("t3_drained", o3_valid, 0);

    // Flush while stalled with two valid entries in flight.
    set_fields(1, 0, 0, 0, 32'h0, 32'hB0, 5'd1, 32'h0);
    v3 = 1;
    @(negedge clk);
    set_fields(1, 0, 0, 0, 32'h0, 32'hC0, 5'd2, 32'h0);
    @(negedge clk);
    v3 = 0; en3 = 0; fl3 = 1;
    @(negedge clk);
    fl3 = 0; en3 = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_flushed_valid", o3_valid, 0);
      chk("t4_flushed_count", o3_cnt, 2);
    end

    // HALT followed by three instructions that must never retire.
    set_fields(0, 0, 0, 1, 32'h0, 32'h11, 5'd0, 32'h0);
    v3 = 1; push(3, 0, 5'd0, 32'h11, 1);
    @(negedge clk);
    set_fields(1, 0, 0, 0, 32'h0, 32'h101, 5'd10, 32'h0);
    @(negedge clk);
    set_fields(1, 0, 0, 0, 32'h0, 32'h102, 5'd11, 32'h0);
    @(negedge clk);
    set_fields(1, 0, 0, 0, 32'h0, 32'h103, 5'd12, 32'h0);
    @(negedge clk);
    v3 = 0;
    chk("t5_halted", o3_halted, 1);
    chk("t5_count", o3_cnt, 3);
    chk("t5_valid", o3_valid, 1);
    chk("t5_write_data", o3_wd, 32'h11);
    chk("t5_reg_write", o3_rw, 0);
    fl3 = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t5_frozen_valid", o3_valid, 1);
      chk("t5_frozen_data", o3_wd, 32'h11);
      chk("t5_frozen_count", o3_cnt, 3);
    end
    fl3 = 0;

    // Counter saturation on a 4-bit counter, then asynchronous reset.
    rst3 = 0;
    @(negedge clk);
    rst3 = 1;
    for (int i = 0; i < 20; i++) begin
      set_fields(1, 0, 0, 0, 32'h0, 32'h200 + i, 5'd3, 32'h0);
      v3 = 1; push(3, 1, 5'd3, 32'h200 + i, 0);
      @(negedge clk);
    end
    v3 = 0;
    repeat (3) @(negedge clk);
    chk("t6_saturated", o3_cnt, 4'hF);
    for (int i = 0; i < 4; i++) begin
      set_fields(1, 0, 0, 0, 32'h0, 32'h300 + i, 5'd4, 32'h0);
      v3 = 1;
      if (i < 2) push(3, 1, 5'd4, 32'h300 + i, 0);
      @(negedge clk);
    end
    v3 = 0;
    chk("t6_pre_reset_valid", o3_valid, 1);
    chk("t6_pre_reset_data", o3_wd, 32'h301);
    chk("t6_pre_reset_count", o3_cnt, 4'hF);
    #2;
    rst3 = 0;
    #1;
    chk("t6_async_valid", o3_valid, 0);
    chk("t6_async_reg_write", o3_rw, 0);
    chk("t6_async_write_reg", o3_wr, 0);
    chk("t6_async_write_data", o3_wd, 0);
    chk("t6_async_count", o3_cnt, 0);
    chk("t6_async_halted", o3_halted, 0);
    @(negedge clk);
    rst3 = 1;
    @(negedge clk);

    chk("q1_drained", q1.size(), 0);
    chk("q3_drained", q3.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
